fir_stream_bridge: RTL and testbench
====================================

# fir_stream_bridge

Wishbone-to-AXI-Stream bridge that drives the FIR/MM accelerator's stream ports from the CPU side. CPU writes go into a TX FIFO, and the bridge emits them as an AXI-Stream master into the accelerator's `ss_*` input. The accelerator's `sm_*` output is captured into an RX FIFO, which the CPU pops over Wishbone. The bridge sits between the user-project Wishbone decoder and the accelerator, and is the stream-side counterpart of the accelerator's slave/master ports.

## Interface
Parameters:
- `pDATA_WIDTH`, 32: stream and Wishbone data width.
- `FIFO_DEPTH`, 8: entries per FIFO; power of 2, range 2..128.

Ports (reset is asynchronous, active-low):
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous active-low reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1  Wishbone strobe, cycle and write enable.
- `wbs_sel_i`  in  4  byte enables.
- `wbs_adr_i`  in  32  address; only `[4:2]` are decoded.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  registered acknowledge.
- `wbs_dat_o`  out  32  registered read data.
- `sm_tvalid`, `sm_tlast`  out  1  stream-out valid and last; connects to the accelerator's `ss_*`.
- `sm_tdata`  out  pDATA_WIDTH  stream-out data.
- `sm_tready`  in  1  stream-out ready.
- `ss_tvalid`, `ss_tlast`  in  1  stream-in valid and last; fed from the accelerator's `sm_*`.
- `ss_tdata`  in  pDATA_WIDTH  stream-in data.
- `ss_tready`  out  1  registered stream-in ready.

## Operation
Register map, selected by `adr[4:2]`:
- **0x00 STATUS.**
  - Read fields:
    - [0] tx_empty
    - [1] tx_full
    - [2] rx_empty
    - [3] rx_full
    - [4] tx_ovf (sticky)
    - [5] rx_udf (sticky)
    - [6] tlast of the RX head entry
    - [15:8] tx_count
    - [23:16] rx_count
  - Write, bit 0: 1 flushes both FIFOs.
  - Write, bits [5:4]: write-1-to-clear the sticky flags.
- **0x04 TXD.** Write pushes `{tlast=0, data}` into the TX FIFO.
- **0x08 TXL.** Write pushes `{tlast=1, data}` into the TX FIFO.
- **0x0C RXD.** Read pops the RX FIFO and returns its data.
- **0x10 FRAMES.** See Configuration.

Register rules:
- Any other address: reads return 0; writes are ignored but acked.
- A TXD/TXL push requires `wbs_sel_i==4'hF`. Any other `sel` is acked and dropped, and no flag is set.

TX path:
- `sm_tvalid = !tx_empty`.
- `sm_tdata`/`sm_tlast` come from the head entry and are forced to 0 when the FIFO is empty.
- An entry is popped on any edge where `sm_tvalid && sm_tready`.
- `sm_tdata`/`sm_tlast` are held stable while valid and not ready.

RX path:
- Push `{ss_tlast, ss_tdata}` on any edge where `ss_tvalid && ss_tready`.

Boundary conditions:
- **Push to full TX:** accepted if a stream pop happens on the same edge; otherwise dropped and tx_ovf is set.
- **RXD read when RX is empty:** fullness is evaluated before any same-edge stream push. Returns 0, sets rx_udf, and nothing is popped.
- **Simultaneous push and pop on the same FIFO:** count is unchanged.
- **Pointer wrap:** pointers wrap modulo FIFO_DEPTH; counts are pointer-width+1 bits.
- **Flush vs same-edge traffic:** flush wins over same-edge pushes and pops. Counts go to 0, sticky flags are unchanged, and the frame counter is cleared.

## Timing
Reset values while `rst_n` is low:
- `wbs_ack_o=0`, `wbs_dat_o=0`
- `sm_tvalid=0`, `sm_tdata=0`, `sm_tlast=0`
- `ss_tready=0`
- FIFOs empty, flags 0

Wishbone:
- When `stb&cyc` is high and `ack` is low, the next edge sets `wbs_ack_o=1` and loads `wbs_dat_o`. The push, pop or flag side effect happens on that same edge.
- `ack` is high for exactly one cycle and then forced low for at least one cycle. Each transfer is therefore 2 cycles minimum.

Stream latency:
- A TX word pushed on edge N gives `sm_tvalid=1` in cycle N+1 if the FIFO was empty.
- `ss_tready` is registered as `rx_count_next < FIFO_DEPTH`. It becomes 1 on the first edge after reset release, and drops in the cycle the FIFO becomes full.
- A received word is readable via RXD from the next cycle.

Reset mid-operation clears everything asynchronously. Partial frames are lost and no sticky state survives.

## Configuration
`FIR_BRIDGE_FRAME_CNT_EN`:
- **Defined:** a 16-bit counter increments on each RX push with `ss_tlast=1` and wraps 0xFFFF→0. It decrements on each RXD pop whose entry has tlast=1, and is unchanged when both occur on the same edge. It is readable at 0x10 and cleared by flush.
- **Undefined:** 0x10 reads 0 and the counter logic is absent.

## Test plan
- **Reset:** hold `rst_n` low for 3 cycles, release → all outputs 0; `ss_tready=1` after the first edge; STATUS reads 0x00000005.
- **TX stream:** write TXD 0x11, 0x22, then TXL 0x33, with `sm_tready=1` → beats 0x11, 0x22, 0x33 with tlast only on 0x33; tx_empty=1 afterwards.
- **Backpressure:** `sm_tready=0`, write FIFO_DEPTH+1 words → tx_full=1, tx_ovf=1, extra word dropped. Release ready → exactly 8 beats in order; write STATUS 0x10 → tx_ovf=0.
- **RX capture:** stream 8 beats (last one with tlast) with `ss_tvalid` held high → `ss_tready=0` after the 8th. Read RXD ×8 → data in order, STATUS[6]=1 before the 8th read. A 9th read returns 0 and sets rx_udf.
- **Flush:** with 3 TX and 2 RX entries, write STATUS 0x1 → tx_count=rx_count=0, `sm_tvalid=0` next cycle.
- **Frame counter (macro defined):** two 4-beat frames received → FRAMES=2; pop 4 words → FRAMES=1.

Source files
------------

// File: rtl/fir_stream_bridge_if.sv
// Bundle of the Wishbone slave port and both AXI-Stream ports of fir_stream_bridge.
// slave = bridge view; master = CPU/accelerator view.
`default_nettype none

interface fir_stream_bridge_if #(
  parameter int pDATA_WIDTH = 32
);
  logic                   wbs_stb_i;
  logic                   wbs_cyc_i;
  logic                   wbs_we_i;
  logic [3:0]             wbs_sel_i;
  logic [31:0]            wbs_adr_i;
  logic [31:0]            wbs_dat_i;
  logic                   wbs_ack_o;
  logic [31:0]            wbs_dat_o;

  logic                   sm_tvalid;
  logic                   sm_tlast;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic                   sm_tready;

  logic                   ss_tvalid;
  logic                   ss_tlast;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   ss_tready;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output sm_tvalid, sm_tlast, sm_tdata,
    input  sm_tready,
    input  ss_tvalid, ss_tlast, ss_tdata,
    output ss_tready
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  sm_tvalid, sm_tlast, sm_tdata,
    output sm_tready,
    output ss_tvalid, ss_tlast, ss_tdata,
    input  ss_tready
  );
endinterface

`default_nettype wire

// File: rtl/fir_stream_bridge.sv
// fir_stream_bridge: Wishbone-to-AXI-Stream bridge with TX/RX FIFOs for the FIR accelerator.
// Optional RX frame counter at 0x10 is enabled by defining FIR_BRIDGE_FRAME_CNT_EN.
`default_nettype none

module fir_stream_bridge #(
  parameter int pDATA_WIDTH = 32,
  parameter int FIFO_DEPTH  = 8
) (
  input  wire                    clk,
  input  wire                    rst_n,
  fir_stream_bridge_if.slave     bus
);
  localparam int            AW      = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int            CW      = AW + 1;
  localparam int            EW      = pDATA_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [2:0]    REG_STATUS = 3'd0;
  localparam logic [2:0]    REG_TXD    = 3'd1;
  localparam logic [2:0]    REG_TXL    = 3'd2;
  localparam logic [2:0]    REG_RXD    = 3'd3;
  localparam logic [2:0]    REG_FRAMES = 3'd4;

  logic [EW-1:0] r_tx_mem [FIFO_DEPTH];
  logic [EW-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW-1:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  logic [CW-1:0] r_tx_cnt, r_rx_cnt, w_tx_cnt_nxt, w_rx_cnt_nxt;
  logic          r_tx_ovf, r_rx_udf, r_ack, r_ss_tready;
  logic [31:0]   r_dat;

  logic          w_req, w_wr, w_rd, w_flush, w_clr_ovf, w_clr_udf;
  logic [2:0]    w_reg;
  logic          w_tx_empty, w_tx_full, w_tx_pop, w_tx_push_req, w_tx_push, w_tx_ovf_set;
  logic          w_rx_empty, w_rx_full, w_rx_push, w_rx_pop_req, w_rx_pop, w_rx_udf_set;
  logic [EW-1:0] w_tx_head, w_rx_head;
  logic [31:0]   w_status, w_rdata;
  logic [15:0]   w_frames;
  logic          w_unused;

  assign w_req   = bus.wbs_stb_i & bus.wbs_cyc_i & ~r_ack;
  assign w_wr    = w_req & bus.wbs_we_i;
  assign w_rd    = w_req & ~bus.wbs_we_i;
  assign w_reg   = bus.wbs_adr_i[4:2];
  assign w_flush   = w_wr & (w_reg == REG_STATUS) & bus.wbs_dat_i[0];
  assign w_clr_ovf = w_wr & (w_reg == REG_STATUS) & bus.wbs_dat_i[4];
  assign w_clr_udf = w_wr & (w_reg == REG_STATUS) & bus.wbs_dat_i[5];
  assign w_unused  = ^{bus.wbs_adr_i[31:5], bus.wbs_adr_i[1:0]};

  assign w_tx_head     = r_tx_mem[r_tx_rd];
  assign w_tx_empty    = (r_tx_cnt == '0);
  assign w_tx_full     = (r_tx_cnt == DEPTH_C);
  assign w_tx_pop      = ~w_tx_empty & bus.sm_tready;
  assign w_tx_push_req = w_wr & ((w_reg == REG_TXD) | (w_reg == REG_TXL)) & (bus.wbs_sel_i == 4'hF);
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_tx_push     = w_tx_push_req & (~w_tx_full | w_tx_pop);
  assign w_tx_ovf_set  = w_tx_push_req & w_tx_full & ~w_tx_pop;

  assign w_rx_head     = r_rx_mem[r_rx_rd];
  assign w_rx_empty    = (r_rx_cnt == '0);
  assign w_rx_full     = (r_rx_cnt == DEPTH_C);
  assign w_rx_push     = bus.ss_tvalid & r_ss_tready;
  assign w_rx_pop_req  = w_rd & (w_reg == REG_RXD);
  assign w_rx_pop      = w_rx_pop_req & ~w_rx_empty;
  assign w_rx_udf_set  = w_rx_pop_req & w_rx_empty;

  assign bus.sm_tvalid = ~w_tx_empty;
  assign bus.sm_tdata  = w_tx_empty ? '0 : w_tx_head[pDATA_WIDTH-1:0];
  assign bus.sm_tlast  = ~w_tx_empty & w_tx_head[EW-1];
  assign bus.ss_tready = r_ss_tready;
  assign bus.wbs_ack_o = r_ack;
  assign bus.wbs_dat_o = r_dat;

  always_comb begin
    w_tx_cnt_nxt = r_tx_cnt;
    w_rx_cnt_nxt = r_rx_cnt;
    if (w_flush) begin
      w_tx_cnt_nxt = '0;
      w_rx_cnt_nxt = '0;
    end else begin
      case ({w_tx_push, w_tx_pop})
        2'b10:   w_tx_cnt_nxt = r_tx_cnt + CW'(1);
        2'b01:   w_tx_cnt_nxt = r_tx_cnt - CW'(1);
        default: w_tx_cnt_nxt = r_tx_cnt;
      endcase
      case ({w_rx_push, w_rx_pop})
        2'b10:   w_rx_cnt_nxt = r_rx_cnt + CW'(1);
        2'b01:   w_rx_cnt_nxt = r_rx_cnt - CW'(1);
        default: w_rx_cnt_nxt = r_rx_cnt;
      endcase
    end
  end

  always_comb begin
    w_status        = '0;
    w_status[0]     = w_tx_empty;
    w_status[1]     = w_tx_full;
    w_status[2]     = w_rx_empty;
    w_status[3]     = w_rx_full;
    w_status[4]     = r_tx_ovf;
    w_status[5]     = r_rx_udf;
    w_status[6]     = ~w_rx_empty & w_rx_head[EW-1];
    w_status[15:8]  = 8'(r_tx_cnt);
    w_status[23:16] = 8'(r_rx_cnt);
  end

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_STATUS: w_rdata = w_status;
      REG_RXD:    w_rdata = w_rx_empty ? '0 : 32'(w_rx_head[pDATA_WIDTH-1:0]);
      REG_FRAMES: w_rdata = 32'(w_frames);
      default:    w_rdata = '0;
    endcase
  end

  // Storage is not reset; outputs are gated by the empty flags instead.
  always_ff @(posedge clk) begin
    if (w_tx_push)
      r_tx_mem[r_tx_wr] <= {(w_reg == REG_TXL), bus.wbs_dat_i[pDATA_WIDTH-1:0]};
    if (w_rx_push)
      r_rx_mem[r_rx_wr] <= {bus.ss_tlast, bus.ss_tdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wr     <= '0;
      r_tx_rd     <= '0;
      r_rx_wr     <= '0;
      r_rx_rd     <= '0;
      r_tx_cnt    <= '0;
      r_rx_cnt    <= '0;
      r_tx_ovf    <= 1'b0;
      r_rx_udf    <= 1'b0;
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_ss_tready <= 1'b0;
    end else begin
      r_ack       <= w_req;
      r_tx_cnt    <= w_tx_cnt_nxt;
      r_rx_cnt    <= w_rx_cnt_nxt;
      r_ss_tready <= (w_rx_cnt_nxt < DEPTH_C);
      if (w_req)
        r_dat <= w_rd ? w_rdata : '0;
      if (w_flush) begin
        r_tx_wr <= '0;
        r_tx_rd <= '0;
        r_rx_wr <= '0;
        r_rx_rd <= '0;
      end else begin
        if (w_tx_push) r_tx_wr <= r_tx_wr + AW'(1);
        if (w_tx_pop)  r_tx_rd <= r_tx_rd + AW'(1);
        if (w_rx_push) r_rx_wr <= r_rx_wr + AW'(1);
        if (w_rx_pop)  r_rx_rd <= r_rx_rd + AW'(1);
      end
      if (w_tx_ovf_set)   r_tx_ovf <= 1'b1;
      else if (w_clr_ovf) r_tx_ovf <= 1'b0;
      if (w_rx_udf_set)   r_rx_udf <= 1'b1;
      else if (w_clr_udf) r_rx_udf <= 1'b0;
    end
  end

`ifdef FIR_BRIDGE_FRAME_CNT_EN
  logic [15:0] r_frames;
  logic        w_frm_inc, w_frm_dec;

  assign w_frm_inc = w_rx_push & bus.ss_tlast;
  assign w_frm_dec = w_rx_pop & w_rx_head[EW-1];
  assign w_frames  = r_frames;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_frames <= '0;
    else if (w_flush)
      r_frames <= '0;
    else if (w_frm_inc & ~w_frm_dec)
      r_frames <= r_frames + 16'd1;
    else if (w_frm_dec & ~w_frm_inc)
      r_frames <= r_frames - 16'd1;
  end
`else
  assign w_frames = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fir_stream_bridge.sv
// Directed self-checking bench for fir_stream_bridge (FIFO_DEPTH = 8).
`default_nettype none

module tb_fir_stream_bridge;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [32:0] beats[$];

  fir_stream_bridge_if #(.pDATA_WIDTH(32)) bus ();

  fir_stream_bridge #(.pDATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake is visible at the negedge before the edge that pops it.
  always @(negedge clk)
    if (rst_n && bus.sm_tvalid && bus.sm_tready)
      beats.push_back({bus.sm_tlast, bus.sm_tdata});

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd);
    logic got;
    got = 1'b0;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.wbs_ack_o) begin
        got = 1'b1;
        break;
      end
    end
    rd = bus.wbs_dat_o;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL wb_ack_timeout: adr %h no ack, required ack within 10 cycles", adr);
    end
  endtask

  task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] d;
    wb_xfer(1'b1, adr, dat, 4'hF, d);
  endtask

  task automatic wb_rd(input logic [31:0] adr, output logic [31:0] rd);
    wb_xfer(1'b0, adr, 32'h0, 4'hF, rd);
  endtask

  task automatic rx_send(input logic [31:0] d, input logic last);
    logic done;
    done = 1'b0;
    bus.ss_tvalid = 1'b1;
    bus.ss_tdata  = d;
    bus.ss_tlast  = last;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ss_tready) begin
        step(1);
        done = 1'b1;
        break;
      end
      step(1);
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_send_timeout: beat %h not accepted, required ss_tready", d);
    end
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    rst_n = 1'b0;
    step(3);
    n_checks++; if (bus.wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.wbs_ack_o); end
    n_checks++; if (bus.wbs_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", bus.wbs_dat_o); end
    n_checks++; if ({bus.sm_tvalid, bus.sm_tlast} !== 2'b00) begin n_fail++; $display("FAIL reset_sm_flags: got %b want 00", {bus.sm_tvalid, bus.sm_tlast}); end
    n_checks++; if (bus.sm_tdata !== 32'h0) begin n_fail++; $display("FAIL reset_sm_tdata: got %h want 0", bus.sm_tdata); end
    n_checks++; if (bus.ss_tready !== 1'b0) begin n_fail++; $display("FAIL reset_ss_tready: got %b want 0", bus.ss_tready); end
    rst_n = 1'b1;
    step(1);
    n_checks++; if (bus.ss_tready !== 1'b1) begin n_fail++; $display("FAIL reset_ss_tready_release: got %b want 1", bus.ss_tready); end
    wb_rd(32'h0, rd);
    n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL reset_status: got %h want 00000005", rd); end
  endtask

  task automatic test_tx_stream;
    logic [31:0] rd;
    logic [32:0] exp [3];
    exp[0] = {1'b0, 32'h11};
    exp[1] = {1'b0, 32'h22};
    exp[2] = {1'b1, 32'h33};
    beats.delete();
    bus.sm_tready = 1'b1;
    wb_wr(32'h4, 32'h11);
    wb_wr(32'h4, 32'h22);
    wb_wr(32'h8, 32'h33);
    step(4);
    n_checks++; if (beats.size() !== 3) begin n_fail++; $display("FAIL tx_beat_count: got %0d want 3", beats.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (beats.size() > i && beats[i] !== exp[i]) begin
        n_fail++; $display("FAIL tx_beat_%0d: got %h want %h", i, beats[i], exp[i]);
      end
    end
    wb_rd(32'h0, rd);
    n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL tx_status_empty: got %h want 00000005", rd); end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd;
    bus.sm_tready = 1'b0;
    beats.delete();
    for (int i = 0; i < 9; i++) wb_wr(32'h4, 32'hA0 + i);
    wb_rd(32'h0, rd);
    n_checks++; if (rd !== 32'h0000_0816) begin n_fail++; $display("FAIL bp_status_full: got %h want 00000816", rd); end
    n_checks++; if ({bus.sm_tvalid, bus.sm_tdata} !== {1'b1, 32'hA0}) begin n_fail++; $display("FAIL bp_hold: got %b/%h want 1/000000a0", bus.sm_tvalid, bus.sm_tdata); end
    bus.sm_tready = 1'b1;
    step(12);
    n_checks++; if (beats.size() !== 8) begin n_fail++; $display("FAIL bp_beat_count: got %0d want 8", beats.size()); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (beats.size() > i && beats[i] !== {1'b0, 32'hA0 + i}) begin
        n_fail++; $display("FAIL bp_beat_%0d: got %h want %h", i, beats[i], {1'b0, 32'hA0 + i});
      end
    end
    wb_wr(32'h0, 32'h10);
    wb_rd(32'h0, rd);
    n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL bp_ovf_clear: got %h want 00000005", rd); end
  endtask

  task automatic test_full_push_pop;
    logic [31:0] rd;
    bus.sm_tready = 1'b0;
    beats.delete();
    for (int i = 0; i < 8; i++) wb_wr(32'h4, 32'hD0 + i);
    step(1);
    bus.sm_tready = 1'b1;
    wb_wr(32'h4, 32'hD8);
    step(12);
    n_checks++; if (beats.size() !== 9) begin n_fail++; $display("FAIL fpp_beat_count: got %0d want 9", beats.size()); end
    n_checks++; if (beats.size() == 9 && beats[8] !== {1'b0, 32'hD8}) begin n_fail++; $display("FAIL fpp_last_beat: got %h want 0d8", beats[8]); end
    wb_rd(32'h0, rd);
    n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL fpp_no_ovf: got %h want 00000005", rd); end
  endtask

  task automatic test_rx_capture;
    logic [31:0] rd;
    for (int i = 0; i < 8; i++) rx_send(32'hB0 + i, (i == 7));
    bus.ss_tvalid = 1'b0;
    bus.ss_tlast  = 1'b0;
    n_checks++; if (bus.ss_tready !== 1'b0) begin n_fail++; $display("FAIL rx_tready_full: got %b want 0", bus.ss_tready); end
    wb_rd(32'h0, rd);
    n_checks++; if (rd !== 32'h0008_0009) begin n_fail++; $display("FAIL rx_status_full: got %h want 00080009", rd); end
    for (int i = 0; i < 7; i++) begin
      wb_rd(32'hC, rd);
      n_checks++; if (rd !== 32'hB0 + i) begin n_fail++; $display("FAIL rx_data_%0d: got %h want %h", i, rd, 32'hB0 + i); end
    end
    wb_rd(32'h0, rd);
    n_checks++; if (rd !== 32'h0001_0041) begin n_fail++; $display("FAIL rx_status_tlast: got %h want 00010041", rd); end
    wb_rd(32'hC, rd);
    n_checks++; if (rd !== 32'hB7) begin n_fail++; $display("FAIL rx_data_7: got %h want 000000b7", rd); end
    wb_rd(32'hC, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rx_underflow_data: got %h want 0", rd); end
    wb_rd(32'h0, rd);
    n_checks++; if (rd !== 32'h25) begin n_fail++; $display("FAIL rx_udf_flag: got %h want 00000025", rd); end
    wb_wr(32'h0, 32'h20);
    wb_rd(32'h0, rd);
    n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL rx_udf_clear: got %h want 00000005", rd); end
  endtask

  task automatic test_flush;
    logic [31:0] rd;
    bus.sm_tready = 1'b0;
    for (int i = 0; i < 3; i++) wb_wr(32'h4, 32'hE0 + i);
    rx_send(32'hC0, 1'b0);
    rx_send(32'hC1, 1'b1);
    bus.ss_tvalid = 1'b0;
    bus.ss_tlast  = 1'b0;
    wb_rd(32'h0, rd);
    n_checks++; if (rd !== 32'h0002_0300) begin n_fail++; $display("FAIL flush_pre_status: got %h want 00020300", rd); end
    wb_wr(32'h0, 32'h1);
    n_checks++; if ({bus.sm_tvalid, bus.sm_tdata} !== 33'h0) begin n_fail++; $display("FAIL flush_sm_tvalid: got %b/%h want 0/0", bus.sm_tvalid, bus.sm_tdata); end
    wb_rd(32'h0, rd);
    n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL flush_status: got %h want 00000005", rd); end
  endtask

  task automatic test_reg_decode;
    logic [31:0] rd;
    wb_rd(32'h14, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL dec_unmapped_read: got %h want 0", rd); end
    wb_wr(32'h18, 32'hFFFF_FFFF);
    bus.sm_tready = 1'b0;
    wb_xfer(1'b1, 32'h4, 32'h55, 4'h3, rd);
    n_checks++; if (bus.sm_tvalid !== 1'b0) begin n_fail++; $display("FAIL dec_partial_sel_push: got tvalid %b want 0", bus.sm_tvalid); end
    wb_rd(32'h0, rd);
    n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL dec_status_clean: got %h want 00000005", rd); end
  endtask

  task automatic test_frame_counter;
    logic [31:0] rd;
`ifdef FIR_BRIDGE_FRAME_CNT_EN
    for (int i = 0; i < 8; i++) rx_send(32'hF0 + i, (i == 3) || (i == 7));
    bus.ss_tvalid = 1'b0;
    bus.ss_tlast  = 1'b0;
    wb_rd(32'h10, rd);
    n_checks++; if (rd !== 32'h2) begin n_fail++; $display("FAIL frames_two: got %h want 2", rd); end
    for (int i = 0; i < 4; i++) wb_rd(32'hC, rd);
    wb_rd(32'h10, rd);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL frames_one: got %h want 1", rd); end
    wb_wr(32'h0, 32'h1);
    wb_rd(32'h10, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL frames_flush: got %h want 0", rd); end
`else
    rx_send(32'hF0, 1'b1);
    bus.ss_tvalid = 1'b0;
    bus.ss_tlast  = 1'b0;
    wb_rd(32'h10, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL frames_absent: got %h want 0", rd); end
    wb_wr(32'h0, 32'h1);
`endif
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    bus.sm_tready = 1'b0;
    wb_wr(32'h4, 32'h77);
    wb_rd(32'hC, rd);
    rst_n = 1'b0;
    #2;
    n_checks++; if ({bus.sm_tvalid, bus.ss_tready, bus.wbs_ack_o} !== 3'b000) begin n_fail++; $display("FAIL mid_reset_outputs: got %b want 000", {bus.sm_tvalid, bus.ss_tready, bus.wbs_ack_o}); end
    step(2);
    rst_n = 1'b1;
    step(1);
    wb_rd(32'h0, rd);
    n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL mid_reset_status: got %h want 00000005", rd); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n         = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
    bus.sm_tready = 1'b0;
    bus.ss_tvalid = 1'b0;
    bus.ss_tlast  = 1'b0;
    bus.ss_tdata  = 32'h0;
    step(1);
    test_reset;
    test_tx_stream;
    test_backpressure;
    test_full_push_pop;
    test_rx_capture;
    test_flush;
    test_reg_decode;
    test_frame_counter;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
